// File: rtl/vx_writeback_arb_pkg.sv
// Shared definitions for the writeback arbiter: commit channel indices, register index width,
// skid buffer state encoding and the round-robin distance helper.
package vx_writeback_arb_pkg;

    localparam int unsigned EX_ALU       = 0;
    localparam int unsigned EX_LSU       = 1;
    localparam int unsigned EX_CSR       = 2;
    localparam int unsigned EX_FPU       = 3;
    localparam int unsigned EX_GPU       = 4;
    localparam int unsigned NUM_EX_UNITS = EX_GPU + 1;

    localparam int unsigned NR_BITS = 5;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } skid_state_e;

    // Position of idx in the search order that starts at ptr and wraps at n.
    function automatic int unsigned rr_dist(input int unsigned idx, input int unsigned ptr,
                                            input int unsigned n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/vx_writeback_arb_skid_buffer.sv
// Two-entry skid buffer with registered outputs; accepts a new word while full if the
// head is being consumed in the same cycle.
module vx_writeback_arb_skid_buffer
    import vx_writeback_arb_pkg::*;
#(
    parameter int unsigned DATAW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DATAW-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DATAW-1:0] data_o
);

    skid_state_e      state_q, state_d;
    logic [DATAW-1:0] slot0_q, slot0_d;
    logic [DATAW-1:0] slot1_q, slot1_d;
    logic             push, pop;

    always_comb begin
        ready_o = (state_q != StFull) || ready_i;
        valid_o = (state_q != StEmpty);
        data_o  = slot0_q;
        push    = valid_i && ready_o;
        pop     = valid_o && ready_i;
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    slot0_d = data_i;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    slot0_d = data_i;
                end else if (push) begin
                    slot1_d = data_i;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // slot0 is always the head; a pop shifts slot1 forward
                if (pop) begin
                    slot0_d = slot1_q;
                    if (push) begin
                        slot1_d = data_i;
                    end else begin
                        state_d = StOne;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

endmodule

// File: rtl/vx_writeback_arb.sv
// Merges the per-unit commit channels into one GPR writeback stream with round-robin
// arbitration, a two-entry output skid buffer and a retired-instruction counter.
module vx_writeback_arb
    import vx_writeback_arb_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_REQS    = NUM_EX_UNITS,
    localparam int unsigned NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             req_valid,
    output logic [NUM_REQS-1:0]             req_ready,
    input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
    input  logic [NUM_REQS*32-1:0]          req_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]     req_rd,
    input  logic [NUM_REQS-1:0]             req_wb,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [NW_BITS-1:0]              wb_wid,
    output logic [NUM_THREADS-1:0]          wb_tmask,
    output logic [31:0]                     wb_PC,
    output logic [NR_BITS-1:0]              wb_rd,
    output logic [NUM_THREADS*32-1:0]       wb_data,
    output logic [63:0]                     instret
);

    localparam int unsigned DATAW = NW_BITS + NUM_THREADS + 32 + NR_BITS + NUM_THREADS * 32;
    localparam int unsigned PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [63:0]         instret_q, instret_d;
    logic [NUM_REQS-1:0] wb_req;
    logic [NUM_REQS-1:0] arb_ready;
    logic [NUM_REQS-1:0] grant;
    logic                grant_valid;
    logic [PTR_W-1:0]    grant_idx;
    logic [DATAW-1:0]    grant_data;
    logic                buf_ready;
    logic [DATAW-1:0]    buf_data;

    assign wb_req = req_valid & req_wb;

    // A channel's ready only looks at the other channels, so it never depends on its own valid.
    always_comb begin
        arb_ready = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            arb_ready[i] = buf_ready;
            for (int unsigned j = 0; j < NUM_REQS; j++) begin
                if (j != i && wb_req[j] &&
                    rr_dist(j, int'(ptr_q), NUM_REQS) < rr_dist(i, int'(ptr_q), NUM_REQS)) begin
                    arb_ready[i] = 1'b0;
                end
            end
        end
    end

    assign grant       = wb_req & arb_ready & {NUM_REQS{reset}};
    assign grant_valid = |grant;

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = reset && (!req_wb[i] || arb_ready[i]);
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                grant_idx  = PTR_W'(i);
                grant_data = {req_wid[i*NW_BITS +: NW_BITS],
                              req_tmask[i*NUM_THREADS +: NUM_THREADS],
                              req_PC[i*32 +: 32],
                              req_rd[i*NR_BITS +: NR_BITS],
                              req_data[i*NUM_THREADS*32 +: NUM_THREADS*32]};
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_comb begin
        instret_d = instret_q;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            instret_d = instret_d + 64'(req_valid[i] & req_ready[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q     <= '0;
            instret_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            instret_q <= instret_d;
        end
    end

    vx_writeback_arb_skid_buffer #(
        .DATAW (DATAW)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (reset),
        .valid_i (grant_valid),
        .ready_o (buf_ready),
        .data_i  (grant_data),
        .valid_o (wb_valid),
        .ready_i (wb_ready),
        .data_o  (buf_data)
    );

    assign {wb_wid, wb_tmask, wb_PC, wb_rd, wb_data} = buf_data;
    assign instret = instret_q;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Scoreboard bench for vx_writeback_arb: a reference model predicts grants and buffered
// writebacks; a monitor compares every presented writeback against the expected queue.
module tb_vx_writeback_arb;
    import vx_writeback_arb_pkg::*;

    localparam int unsigned NT  = 4;
    localparam int unsigned NWP = 4;
    localparam int unsigned NR  = 5;
    localparam int unsigned NWB = 2;
    localparam int unsigned DW  = NWB + NT + 32 + NR_BITS + NT * 32;

    logic clk = 1'b0;
    logic reset;
    logic [NR-1:0]         req_valid, req_ready, req_wb;
    logic [NR*NWB-1:0]     req_wid;
    logic [NR*NT-1:0]      req_tmask;
    logic [NR*32-1:0]      req_PC;
    logic [NR*NR_BITS-1:0] req_rd;
    logic [NR*NT*32-1:0]   req_data;
    logic                  wb_valid, wb_ready;
    logic [NWB-1:0]        wb_wid;
    logic [NT-1:0]         wb_tmask;
    logic [31:0]           wb_PC;
    logic [NR_BITS-1:0]    wb_rd;
    logic [NT*32-1:0]      wb_data;
    logic [63:0]           instret;

    logic [DW-1:0] pay [NR];
    logic [DW-1:0] exp_q [$];
    logic [NR-1:0] xfer;
    logic [NR-1:0] exp_ready;
    logic [63:0]   m_instret;
    int            m_ptr;
    bit            mon_en;
    int            checks;
    int            failures;

    always #5 clk = ~clk;

    vx_writeback_arb #(
        .NUM_THREADS (NT),
        .NUM_WARPS   (NWP),
        .NUM_REQS    (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wid   (req_wid),
        .req_tmask (req_tmask),
        .req_PC    (req_PC),
        .req_rd    (req_rd),
        .req_wb    (req_wb),
        .req_data  (req_data),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_wid    (wb_wid),
        .wb_tmask  (wb_tmask),
        .wb_PC     (wb_PC),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .instret   (instret)
    );

    always_comb begin
        req_wid   = '0;
        req_tmask = '0;
        req_PC    = '0;
        req_rd    = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            {req_wid[i*NWB +: NWB], req_tmask[i*NT +: NT], req_PC[i*32 +: 32],
             req_rd[i*NR_BITS +: NR_BITS], req_data[i*NT*32 +: NT*32]} = pay[i];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_pay();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Reference model: evaluated between the monitor and the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (mon_en) check("ready_in_reset", DW'(req_ready), DW'(0));
            xfer = '0;
            exp_q.delete();
            m_ptr = 0;
            m_instret = '0;
        end else begin
            bit accept;
            bit blocked;
            int winner;
            accept  = exp_q.size() < 2;
            blocked = 1'b0;
            winner  = -1;
            exp_ready = '0;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (!req_wb[idx]) begin
                    exp_ready[idx] = 1'b1;
                end else begin
                    exp_ready[idx] = accept && !blocked;
                    if (req_valid[idx]) begin
                        if (!blocked && accept) winner = idx;
                        blocked = 1'b1;
                    end
                end
            end
            if (mon_en) check("req_ready", DW'(req_ready), DW'(exp_ready));
            xfer = req_valid & exp_ready;
            if (winner >= 0) begin
                exp_q.push_back(pay[winner]);
                m_ptr = (winner + 1) % NR;
            end
            m_instret = m_instret + 64'($countones(xfer));
        end
    end

    // Monitor: compares the presented writeback against the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            check("wb_valid", DW'(wb_valid), DW'(exp_q.size() > 0));
            if (wb_valid && exp_q.size() > 0) begin
                check("wb_payload", {wb_wid, wb_tmask, wb_PC, wb_rd, wb_data}, exp_q[0]);
                if (wb_ready) void'(exp_q.pop_front());
            end
            check("instret", DW'(instret), DW'(m_instret));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int i, input bit v, input bit wb);
        req_valid[i] = v;
        req_wb[i]    = wb;
        pay[i]       = rand_pay();
    endtask

    task automatic refresh();
        for (int i = 0; i < NR; i++) if (xfer[i]) pay[i] = rand_pay();
    endtask

    task automatic retire();
        for (int i = 0; i < NR; i++) if (xfer[i]) req_valid[i] = 1'b0;
    endtask

    initial begin
        int acc;
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b0;
        reset     = 1'b0;
        wb_ready  = 1'b0;
        req_valid = '0;
        req_wb    = '0;
        xfer      = '0;
        m_ptr     = 0;
        m_instret = '0;
        for (int i = 0; i < NR; i++) pay[i] = '0;
        repeat (3) next_cycle();
        mon_en = 1'b1;
        check("reset_wb_valid", DW'(wb_valid), DW'(0));
        check("reset_instret", DW'(instret), DW'(0));

        // ALU and LSU on the first cycle out of reset
        reset    = 1'b1;
        wb_ready = 1'b1;
        set_chan(EX_ALU, 1'b1, 1'b1);
        set_chan(EX_LSU, 1'b1, 1'b1);
        repeat (4) begin next_cycle(); retire(); end

        // All channels streaming, wrap of the pointer
        for (int i = 0; i < NR; i++) set_chan(i, 1'b1, 1'b1);
        repeat (12) begin next_cycle(); refresh(); end
        repeat (7) begin next_cycle(); retire(); end

        // Non-writeback commit alongside a writeback commit
        set_chan(EX_CSR, 1'b1, 1'b0);
        set_chan(EX_GPU, 1'b1, 1'b1);
        repeat (3) begin next_cycle(); retire(); end

        // Output stall with FPU streaming
        wb_ready = 1'b0;
        set_chan(EX_FPU, 1'b1, 1'b1);
        acc = 0;
        repeat (4) begin
            @(negedge clk);
            #2;
            acc += int'(req_valid[EX_FPU] && req_ready[EX_FPU]);
            next_cycle();
            refresh();
        end
        check("stall_accepts", DW'(acc), DW'(2));
        wb_ready = 1'b1;
        repeat (6) begin next_cycle(); refresh(); end
        repeat (3) begin next_cycle(); retire(); end

        // Reset with two entries buffered
        wb_ready = 1'b0;
        set_chan(EX_FPU, 1'b1, 1'b1);
        repeat (4) begin next_cycle(); refresh(); end
        reset = 1'b0;
        next_cycle();
        check("rst_mid_wb_valid", DW'(wb_valid), DW'(0));
        check("rst_mid_instret", DW'(instret), DW'(0));
        reset = 1'b1;
        set_chan(EX_ALU, 1'b1, 1'b1);
        set_chan(EX_GPU, 1'b1, 1'b1);
        wb_ready = 1'b1;
        repeat (6) begin next_cycle(); retire(); end

        // Counter wrap: preload all-ones through the next-state value
        force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
        next_cycle();
        release dut.instret_d;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        set_chan(EX_ALU, 1'b1, 1'b0);
        next_cycle();
        retire();
        check("instret_wrap", DW'(instret), DW'(0));
        next_cycle();

        // Randomized traffic with occasional resets
        repeat (400) begin
            next_cycle();
            reset = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || xfer[i]) begin
                    set_chan(i, $urandom_range(0, 99) < 55, $urandom_range(0, 3) != 0);
                end
            end
            wb_ready = $urandom_range(0, 99) < 70;
        end

        reset    = 1'b1;
        wb_ready = 1'b1;
        repeat (10) begin next_cycle(); retire(); end
        @(negedge clk);
        #2;
        check("drain_wb_valid", DW'(wb_valid), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
